// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio codec arbiter: sample type, FSM states
// and the saturating sample adder.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {IDLE, PLAY} arb_state_t;

  localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
  localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}});

  // One guard bit catches overflow; clamp to the representable extremes.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
      sat_add = sum[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
    end else begin
      sat_add = sample_t'(sum[SAMPLE_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/audio_arbiter_if.sv
// Codec handshake plus sound-source bus between the sources, the arbiter and the codec.
interface audio_arbiter_if
  import audio_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                        read_ready;
  logic                        write_ready;
  logic                        read;
  logic                        write;
  logic                        sample_en;
  logic [NUM_SRC-1:0]          req;
  logic [NUM_SRC*SAMPLE_W-1:0] src_sample;
  sample_t                     writedata_left;
  sample_t                     writedata_right;
  logic [SRC_W-1:0]            active_src;
  logic                        busy;

  modport master (
    input  read_ready, write_ready, req, src_sample,
    output read, write, sample_en, writedata_left, writedata_right, active_src, busy
  );

  modport slave (
    output read_ready, write_ready, req, src_sample,
    input  read, write, sample_en, writedata_left, writedata_right, active_src, busy
  );

endinterface

// File: rtl/sample_mixer.sv
// Ducks the music by an arithmetic shift and adds it to the effect with saturation.
module sample_mixer
  import audio_pkg::*;
#(
  parameter int unsigned DUCK_SHIFT = 1
) (
  input  sample_t music,
  input  sample_t effect,
  output sample_t mix_c
);

  sample_t ducked_c;

  assign ducked_c = music >>> DUCK_SHIFT;
  assign mix_c    = sat_add(effect, ducked_c);

endmodule

// File: rtl/audio_arbiter.sv
// Fixed-priority owner of the codec write channel: music at index 0, one-shot
// effects above it, each effect timed in transferred codec samples.
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned DUCK_SHIFT   = 1
) (
  input logic             clk,
  input logic             reset,
  audio_arbiter_if.master bus
);

  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);

  arb_state_t         state;
  logic [SRC_W-1:0]   owner;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [NUM_SRC-1:0] pending;
  sample_t            writedata;

  logic               xfer_c;
  logic               expire_c;
  logic [NUM_SRC-1:0] new_req_c;
  logic [NUM_SRC-1:0] cand_c;
  logic [SRC_W-1:0]   hi_req_c;
  logic [SRC_W-1:0]   hi_cand_c;
  sample_t            music_c;
  sample_t            effect_c;
  sample_t            mix_c;

  assign xfer_c        = bus.read_ready & bus.write_ready;
  assign bus.read      = xfer_c;
  assign bus.write     = xfer_c;
  assign bus.sample_en = xfer_c;

  // Music never requests ownership; it only plays when nothing else does.
  assign new_req_c = bus.req & ~NUM_SRC'(1);
  assign cand_c    = new_req_c | pending;
  assign expire_c  = (state == PLAY) && xfer_c && (hold_cnt == HOLD_W'(1));

  // Priority encoders: later (higher) indices overwrite earlier ones.
  always_comb begin
    hi_req_c  = '0;
    hi_cand_c = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (new_req_c[i]) hi_req_c = SRC_W'(i);
      if (cand_c[i])    hi_cand_c = SRC_W'(i);
    end
  end

  // Current owner's sample; music is lane 0.
  always_comb begin
    effect_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (owner == SRC_W'(i)) effect_c = sample_t'(bus.src_sample[i*SAMPLE_W +: SAMPLE_W]);
    end
  end

  assign music_c = sample_t'(bus.src_sample[SAMPLE_W-1:0]);

  sample_mixer #(
    .DUCK_SHIFT (DUCK_SHIFT)
  ) u_mixer (
    .music  (music_c),
    .effect (effect_c),
    .mix_c  (mix_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      hold_cnt  <= '0;
      pending   <= '0;
      writedata <= '0;
    end else begin
      writedata <= (state == PLAY) ? mix_c : music_c;
      if (expire_c) begin
        // Expiry and fresh requests compete together for the next owner.
        owner   <= hi_cand_c;
        pending <= cand_c & ~(NUM_SRC'(1) << hi_cand_c);
        if (hi_cand_c != '0) begin
          state    <= PLAY;
          hold_cnt <= HOLD_INIT;
        end else begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      end else if ((new_req_c != '0) && (hi_req_c >= owner)) begin
        // Preempt or retrigger; the displaced owner is dropped, not queued.
        state    <= PLAY;
        owner    <= hi_req_c;
        hold_cnt <= HOLD_INIT;
        pending  <= pending | (new_req_c & ~(NUM_SRC'(1) << hi_req_c));
      end else begin
        pending <= pending | new_req_c;
        if ((state == PLAY) && xfer_c) hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  assign bus.writedata_left  = writedata;
  assign bus.writedata_right = writedata;
  assign bus.active_src      = owner;
  assign bus.busy            = (state == PLAY);

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench for audio_arbiter: directed scenarios plus random traffic,
// compared each cycle against a behavioural model of the arbitration rules.
module tb_audio_arbiter;
  import audio_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int HOLD    = 4800;
  localparam int DUCK    = 1;
  localparam int SRC_W   = 2;
  localparam int MAXV    = (1 << (SAMPLE_W - 1)) - 1;
  localparam int MINV    = -(1 << (SAMPLE_W - 1));

  logic clk = 1'b0;
  logic reset;

  audio_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  audio_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .HOLD_SAMPLES (HOLD),
    .DUCK_SHIFT   (DUCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_owner = 0;
  int m_hold  = 0;
  bit m_pend[NUM_SRC];
  int exp_wd  = 0;
  int src_v[NUM_SRC];

  function automatic int clamp(int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int rand_sample();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) begin
      if ($urandom_range(0, 1) == 1) return MAXV - int'($urandom_range(0, 15));
      return MINV + int'($urandom_range(0, 15));
    end
    return int'($urandom_range(0, 16777215)) - (1 << (SAMPLE_W - 1));
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NUM_SRC; i++) bus.src_sample[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(src_v[i]);
  endtask

  task automatic randomize_src();
    for (int i = 0; i < NUM_SRC; i++) src_v[i] = rand_sample();
    drive_src();
  endtask

  // Advance one clock; the model applies the spec rules to the inputs seen at the edge.
  task automatic tick();
    int n_owner, n_hold, n_wd, hi_new, hi_pend, win;
    bit n_pend[NUM_SRC];
    bit xfer;
    xfer    = bus.read_ready && bus.write_ready;
    n_owner = m_owner;
    n_hold  = m_hold;
    n_pend  = m_pend;
    hi_new  = 0;
    hi_pend = 0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (bus.req[i]) hi_new = i;
      if (m_pend[i])  hi_pend = i;
    end
    if (m_owner == 0) n_wd = src_v[0];
    else              n_wd = clamp(src_v[m_owner] + (src_v[0] >>> DUCK));
    if (m_owner != 0 && xfer && m_hold == 1) begin
      win     = (hi_new > hi_pend) ? hi_new : hi_pend;
      n_owner = win;
      n_hold  = (win != 0) ? HOLD : 0;
    end else if (hi_new != 0 && hi_new >= m_owner) begin
      n_owner = hi_new;
      n_hold  = HOLD;
    end else if (m_owner != 0 && xfer) begin
      n_hold = m_hold - 1;
    end
    for (int i = 1; i < NUM_SRC; i++) begin
      if (bus.req[i] && i != n_owner) n_pend[i] = 1'b1;
    end
    if (n_owner != 0) n_pend[n_owner] = 1'b0;
    if (reset) begin
      n_owner = 0;
      n_hold  = 0;
      n_wd    = 0;
      for (int i = 0; i < NUM_SRC; i++) n_pend[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_owner = n_owner;
    m_hold  = n_hold;
    m_pend  = n_pend;
    exp_wd  = n_wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.read_ready  = 1'b1;
    bus.write_ready = 1'b1;
    bus.req = '0;
    for (int i = 0; i < NUM_SRC; i++) src_v[i] = 0;
    src_v[0] = 1000;
    drive_src();
    tick();
    tick();
    checks++;
    if (bus.active_src !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: active_src=%0d busy=%0b, expected 0 0", bus.active_src, bus.busy);
    end
    checks++;
    if (bus.writedata_left !== 24'd0 || bus.writedata_right !== 24'd0) begin
      errors++;
      $display("FAIL reset_writedata: %0d/%0d, expected 0", bus.writedata_left, bus.writedata_right);
    end
    checks++;
    if (bus.read !== 1'b1 || bus.write !== 1'b1 || bus.sample_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: read=%0b write=%0b en=%0b, expected 1 1 1", bus.read, bus.write, bus.sample_en);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.writedata_left !== 24'd1000 || bus.writedata_right !== 24'd1000) begin
      errors++;
      $display("FAIL reset_music: %0d/%0d, expected 1000", bus.writedata_left, bus.writedata_right);
    end
    bus.read_ready = 1'b0;
    #1;
    checks++;
    if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.sample_en !== 1'b0) begin
      errors++;
      $display("FAIL handshake_low: read=%0b write=%0b en=%0b, expected 0 0 0", bus.read, bus.write, bus.sample_en);
    end
    bus.read_ready = 1'b1;
  endtask

  task automatic test_hold_count();
    int xfers = 0;
    bit pre_busy, xfer, done = 1'b0;
    randomize_src();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    for (int c = 0; c < 20000 && !done; c++) begin
      bus.read_ready = 1'($urandom_range(0, 1));
      pre_busy = bus.busy;
      xfer     = bus.read_ready;
      tick();
      if (pre_busy && xfer) xfers++;
      checks++;
      if (bus.active_src !== SRC_W'(m_owner) || bus.busy !== (m_owner != 0)) begin
        errors++;
        $display("FAIL hold_owner: active_src=%0d busy=%0b, expected %0d", bus.active_src, bus.busy, m_owner);
      end
      checks++;
      if (bus.writedata_left !== SAMPLE_W'(exp_wd) || bus.writedata_right !== SAMPLE_W'(exp_wd)) begin
        errors++;
        $display("FAIL hold_mix: %0d/%0d, expected %0d", bus.writedata_left, bus.writedata_right, exp_wd);
      end
      if (!bus.busy) done = 1'b1;
    end
    bus.read_ready = 1'b1;
    checks++;
    if (xfers != HOLD || bus.active_src !== 2'd0) begin
      errors++;
      $display("FAIL hold_length: %0d xfers, active_src=%0d, expected %0d xfers then 0", xfers, bus.active_src, HOLD);
    end
  endtask

  task automatic test_saturation();
    src_v[0] = 32'h100;
    src_v[1] = 32'h7FFFF0;
    src_v[2] = 0;
    src_v[3] = 0;
    drive_src();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    checks++;
    if (bus.active_src !== 2'd1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_owner: active_src=%0d busy=%0b, expected 1 1", bus.active_src, bus.busy);
    end
    tick();
    checks++;
    if (bus.writedata_left !== 24'h7FFFFF || bus.writedata_right !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL sat_pos: %h/%h, expected 7fffff", bus.writedata_left, bus.writedata_right);
    end
    src_v[1] = MINV;
    src_v[0] = -2;
    drive_src();
    tick();
    checks++;
    if (bus.writedata_left !== 24'h800000 || bus.writedata_right !== 24'h800000) begin
      errors++;
      $display("FAIL sat_neg: %h/%h, expected 800000", bus.writedata_left, bus.writedata_right);
    end
  endtask

  task automatic test_preempt();
    randomize_src();
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (bus.active_src !== SRC_W'(m_owner) || bus.writedata_left !== SAMPLE_W'(exp_wd)) begin
        errors++;
        $display("FAIL preempt_run: active_src=%0d wd=%0d, expected %0d %0d", bus.active_src, bus.writedata_left, m_owner, exp_wd);
      end
    end
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    checks++;
    if (bus.active_src !== 2'd3) begin
      errors++;
      $display("FAIL preempt_owner: active_src=%0d, expected 3", bus.active_src);
    end
    for (int c = 0; c < HOLD - 1; c++) begin
      tick();
      checks++;
      if (bus.active_src !== SRC_W'(m_owner) || bus.writedata_left !== SAMPLE_W'(exp_wd)) begin
        errors++;
        $display("FAIL preempt_hold: active_src=%0d wd=%0d, expected %0d %0d", bus.active_src, bus.writedata_left, m_owner, exp_wd);
      end
    end
    checks++;
    if (bus.active_src !== 2'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL preempt_reload: active_src=%0d busy=%0b, expected 3 1", bus.active_src, bus.busy);
    end
    tick();
    checks++;
    if (bus.active_src !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_no_resume: active_src=%0d busy=%0b, expected 0 0", bus.active_src, bus.busy);
    end
  endtask

  task automatic test_pending();
    randomize_src();
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    for (int c = 0; c < 10; c++) tick();
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    checks++;
    if (bus.active_src !== 2'd3) begin
      errors++;
      $display("FAIL pending_keep: active_src=%0d, expected 3", bus.active_src);
    end
    for (int c = 0; c < 6000 && bus.active_src == 2'd3; c++) begin
      tick();
      checks++;
      if (bus.active_src !== SRC_W'(m_owner) || bus.writedata_left !== SAMPLE_W'(exp_wd)) begin
        errors++;
        $display("FAIL pending_run: active_src=%0d wd=%0d, expected %0d %0d", bus.active_src, bus.writedata_left, m_owner, exp_wd);
      end
    end
    checks++;
    if (bus.active_src !== 2'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pending_grant: active_src=%0d busy=%0b, expected 2 1", bus.active_src, bus.busy);
    end
    for (int c = 0; c < HOLD - 1; c++) tick();
    checks++;
    if (bus.active_src !== 2'd2) begin
      errors++;
      $display("FAIL pending_length: active_src=%0d, expected 2", bus.active_src);
    end
    tick();
    checks++;
    if (bus.active_src !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL pending_done: active_src=%0d busy=%0b, expected 0 0", bus.active_src, bus.busy);
    end
  endtask

  task automatic test_retrigger_and_reset();
    randomize_src();
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    for (int c = 0; c < HOLD - 1; c++) tick();
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    checks++;
    if (bus.active_src !== 2'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL retrig_owner: active_src=%0d busy=%0b, expected 2 1", bus.active_src, bus.busy);
    end
    for (int c = 0; c < HOLD - 1; c++) tick();
    checks++;
    if (bus.active_src !== 2'd2) begin
      errors++;
      $display("FAIL retrig_reload: active_src=%0d, expected 2", bus.active_src);
    end
    tick();
    checks++;
    if (bus.active_src !== 2'd0) begin
      errors++;
      $display("FAIL retrig_done: active_src=%0d, expected 0", bus.active_src);
    end
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.active_src !== 2'd0 || bus.writedata_left !== 24'd0 || bus.writedata_right !== 24'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%0b active_src=%0d wd=%0d, expected 0 0 0", bus.busy, bus.active_src, bus.writedata_left);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.writedata_left !== SAMPLE_W'(src_v[0])) begin
      errors++;
      $display("FAIL reset_no_pending: busy=%0b wd=%0d, expected 0 %0d", bus.busy, bus.writedata_left, src_v[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6000; c++) begin
      bus.read_ready  = ($urandom_range(0, 3) != 0);
      bus.write_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_SRC; i++) bus.req[i] = ($urandom_range(0, 299) == 0);
      randomize_src();
      #1;
      checks++;
      if (bus.read !== (bus.read_ready & bus.write_ready) || bus.write !== bus.read || bus.sample_en !== bus.read) begin
        errors++;
        $display("FAIL rand_handshake: read=%0b write=%0b en=%0b", bus.read, bus.write, bus.sample_en);
      end
      tick();
      checks++;
      if (bus.active_src !== SRC_W'(m_owner) || bus.busy !== (m_owner != 0)) begin
        errors++;
        $display("FAIL rand_owner: active_src=%0d busy=%0b, expected %0d", bus.active_src, bus.busy, m_owner);
      end
      checks++;
      if (bus.writedata_left !== SAMPLE_W'(exp_wd) || bus.writedata_right !== SAMPLE_W'(exp_wd)) begin
        errors++;
        $display("FAIL rand_mix: %0d/%0d, expected %0d", bus.writedata_left, bus.writedata_right, exp_wd);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_hold_count();
    test_saturation();
    test_preempt();
    test_pending();
    test_retrigger_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
